axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE: AXI4 master with INCR bursts of 1..256 beats and independent, concurrent read and write engines.
//  User side issues a command (address, length), then streams beats with valid/ready. Block drives AXI4 AW/W/B/AR/R.
//  Sits between DMA/CPU-side logic and the AXI interconnect. Successor to the single-beat master.
// PARAMETERS:
//  DATA_WIDTH      32  data bus width in bits; one of 32, 64, 128. BYTES = DATA_WIDTH/8.
//  ADDR_WIDTH      32  address width in bits (>= 12).
//  BOUNDARY_CHECK  1   1: reject bursts crossing a 4 KB boundary. 0: no check.
// PORTS:
//  aclk           in   1        clock; all logic on rising edge
//  aresetn        in   1        asynchronous active-low reset
//  wr_req         in   1        write command; accepted on the cycle where wr_req && !wr_busy
//  wr_addr        in   ADDR     burst start byte address; low log2(BYTES) bits are forced to 0
//  wr_len         in   8        beats-1 (AXI AWLEN encoding)
//  wr_data        in   DATA     write beat data
//  wr_strb        in   BYTES    write beat byte strobes
//  wr_valid       in   1        write beat valid
//  wr_ready       out  1        write beat accepted when wr_valid && wr_ready
//  wr_done        out  1        1-cycle pulse at end of write command
//  wr_resp        out  2        BRESP (or 2'b10 on reject); valid while wr_done=1
//  wr_busy        out  1        write engine not idle
//  rd_req         in   1        read command; accepted on the cycle where rd_req && !rd_busy
//  rd_addr        in   ADDR     burst start byte address; low bits forced to 0
//  rd_len         in   8        beats-1
//  rd_data        out  DATA     read beat data (m_axi_rdata passed through)
//  rd_valid       out  1        read beat valid
//  rd_ready       in   1        user accepts read beat
//  rd_done        out  1        1-cycle pulse, one cycle after the RLAST handshake (or the reject)
//  rd_resp        out  2        worst (max) RRESP over the burst; 2'b10 on reject or RLAST mismatch
//  rd_busy        out  1        read engine not idle
//  m_axi_aw*      mix  -        out: awaddr[ADDR], awlen[8], awsize[3]=log2(BYTES), awburst[2]=2'b01, awprot=0, awvalid; in: awready
//  m_axi_w*       mix  -        out: wdata, wstrb, wlast, wvalid; in: wready
//  m_axi_b*       mix  -        in: bresp[2], bvalid; out: bready
//  m_axi_ar*      mix  -        out: araddr, arlen, arsize, arburst=INCR, arprot=0, arvalid; in: arready
//  m_axi_r*       mix  -        in: rdata, rresp[2], rlast, rvalid; out: rready
// BEHAVIOUR:
//  Reset (async, immediate): all valid and ready outputs = 0, wr_done = rd_done = 0, wr_resp = rd_resp = 0, busy = 0.
//   Both FSMs go to IDLE. A reset mid-burst abandons the burst; no done pulse is produced.
//  Read and write engines are fully independent. No arbitration between them; both may be active in the same cycle.
//  Write FSM: W_IDLE -> W_XFER -> W_RESP -> W_IDLE.
//   On accept: register addr/len. Next cycle awvalid = 1, held until awready. Beat counter = 0.
//   W_XFER: m_axi_wvalid = wr_valid; wr_ready = m_axi_wready; wdata/wstrb pass through combinationally.
//   W_XFER: wlast = (counter == len). Counter increments on each W handshake.
//   W beats may precede, coincide with, or follow the AW handshake. Leave W_XFER when the AW handshake and the
//   last W handshake have both completed; they may occur in either order or in the same cycle.
//   W_RESP: bready = 1. On bvalid: capture bresp, pulse wr_done next cycle, return to W_IDLE.
//  Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
//   R_ADDR: arvalid = 1 until arready.
//   R_DATA: rready = rd_ready; rd_valid = rvalid. Accumulate rd_resp = max(rd_resp, rresp) and count beats.
//   On the RLAST handshake: if count != len, force rd_resp = 2'b10. Pulse rd_done next cycle, return to R_IDLE.
//  4 KB check (BOUNDARY_CHECK = 1): reject when addr[11:0] + (len+1)*BYTES > 4096.
//   A rejected command issues no bus activity and pulses done with resp = 2'b10 two cycles after accept.
//   Exactly 4096 is legal.
//  Width rules: the boundary sum is computed in 14 bits, so no overflow. Beat counter is 8 bits; len = 255 gives 256 beats.
//  busy rises the cycle after accept and falls in the same cycle as the done pulse.
//   A new command may be accepted while done = 1.
//  AXI stability: once asserted, awvalid/arvalid and their address/len are held until the handshake.
// TESTING:
//  Write addr=0x100, len=3, slave ready always -> 4 W beats, wlast on beat 4, awlen=3, wr_done with wr_resp=0.
//  Write with awready delayed 10 cycles while wready=1 -> all 4 beats accepted before AW; exactly one wr_done.
//  Concurrent read 0x200 len=7 and write 0x300 len=0 -> both complete; rd_resp=0; 8 beats delivered in order.
//  Read with rresp=2'b01 on beat 2, and a read with rlast on beat 3 of len=7 -> rd_resp=1, and rd_resp=2 respectively.
//  Write addr=0xFF0, len=3, DATA=32 -> accepted (ends at 4096); addr=0xFF4, len=3 -> rejected: no awvalid, wr_resp=2.
//  aresetn low mid read burst -> arvalid/rready drop immediately; after release, a new read completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI4 burst master: independent write (AW/W/B) and read (AR/R) engines, INCR bursts of 1..256 beats,
// with optional rejection of bursts that would cross a 4 KB page.
module axi_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter bit BOUNDARY_CHECK = 1'b1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    // user write side
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]              wr_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic                    wr_done,
    output logic [1:0]              wr_resp,
    output logic                    wr_busy,
    // user read side
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [7:0]              rd_len,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    rd_done,
    output logic [1:0]              rd_resp,
    output logic                    rd_busy,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // AXI read address / data
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
    localparam logic [2:0] AX_SIZE = 3'(LSB);

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_REJ} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_REJ} r_state_e;

    w_state_e              w_state_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [7:0]            w_len_q;
    logic [7:0]            w_cnt_q;
    logic                  w_last_seen_q;
    logic                  aw_valid_q;
    logic                  wr_done_q;
    logic [1:0]            wr_resp_q;

    r_state_e              r_state_q;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [7:0]            r_len_q;
    logic [7:0]            r_cnt_q;
    logic                  rd_done_q;
    logic [1:0]            rd_resp_q;

    logic [ADDR_WIDTH-1:0] wr_addr_al, rd_addr_al;
    logic [13:0]           wr_end_d, rd_end_d;
    logic                  wr_reject_d, rd_reject_d;
    logic                  w_xfer, w_hs, r_hs;
    logic [1:0]            rresp_max_d;

    assign wr_addr_al = wr_addr & ALIGN_MASK;
    assign rd_addr_al = rd_addr & ALIGN_MASK;

    // 14-bit end offset: max is 4095 + 256*16, so the sum cannot wrap
    assign wr_end_d    = {2'b00, wr_addr_al[11:0]} + (({6'b0, wr_len} + 14'd1) << LSB);
    assign rd_end_d    = {2'b00, rd_addr_al[11:0]} + (({6'b0, rd_len} + 14'd1) << LSB);
    assign wr_reject_d = BOUNDARY_CHECK && (wr_end_d > 14'd4096);
    assign rd_reject_d = BOUNDARY_CHECK && (rd_end_d > 14'd4096);

    assign w_xfer        = (w_state_q == W_XFER);
    assign m_axi_awaddr  = w_addr_q;
    assign m_axi_awlen   = w_len_q;
    assign m_axi_awsize  = AX_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = aw_valid_q;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = wr_strb;
    assign m_axi_wvalid  = w_xfer && !w_last_seen_q && wr_valid;
    assign m_axi_wlast   = w_xfer && (w_cnt_q == w_len_q);
    assign wr_ready      = w_xfer && !w_last_seen_q && m_axi_wready;
    assign m_axi_bready  = (w_state_q == W_RESP);
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign wr_done       = wr_done_q;
    assign wr_resp       = wr_resp_q;
    assign wr_busy       = (w_state_q != W_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q     <= W_IDLE;
            w_addr_q      <= '0;
            w_len_q       <= '0;
            w_cnt_q       <= '0;
            w_last_seen_q <= 1'b0;
            aw_valid_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            wr_resp_q     <= 2'b00;
        end else begin
            wr_done_q <= 1'b0;
            case (w_state_q)
                W_IDLE: if (wr_req) begin
                    w_addr_q      <= wr_addr_al;
                    w_len_q       <= wr_len;
                    w_cnt_q       <= '0;
                    w_last_seen_q <= 1'b0;
                    if (wr_reject_d) begin
                        w_state_q <= W_REJ;
                    end else begin
                        w_state_q  <= W_XFER;
                        aw_valid_q <= 1'b1;
                    end
                end
                W_XFER: begin
                    if (m_axi_awready) aw_valid_q <= 1'b0;
                    if (w_hs) begin
                        w_cnt_q <= w_cnt_q + 8'd1;
                        if (m_axi_wlast) w_last_seen_q <= 1'b1;
                    end
                    // AW and the final W beat may complete in either order or together
                    if ((!aw_valid_q || m_axi_awready) && (w_last_seen_q || (w_hs && m_axi_wlast)))
                        w_state_q <= W_RESP;
                end
                W_RESP: if (m_axi_bvalid) begin
                    wr_resp_q <= m_axi_bresp;
                    wr_done_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                W_REJ: begin
                    wr_resp_q <= 2'b10;
                    wr_done_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign m_axi_araddr  = r_addr_q;
    assign m_axi_arlen   = r_len_q;
    assign m_axi_arsize  = AX_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state_q == R_ADDR);
    assign m_axi_rready  = (r_state_q == R_DATA) && rd_ready;
    assign rd_valid      = (r_state_q == R_DATA) && m_axi_rvalid;
    assign rd_data       = m_axi_rdata;
    assign r_hs          = m_axi_rvalid && m_axi_rready;
    assign rresp_max_d   = (m_axi_rresp > rd_resp_q) ? m_axi_rresp : rd_resp_q;
    assign rd_done       = rd_done_q;
    assign rd_resp       = rd_resp_q;
    assign rd_busy       = (r_state_q != R_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            rd_done_q <= 1'b0;
            rd_resp_q <= 2'b00;
        end else begin
            rd_done_q <= 1'b0;
            case (r_state_q)
                R_IDLE: if (rd_req) begin
                    r_addr_q  <= rd_addr_al;
                    r_len_q   <= rd_len;
                    r_cnt_q   <= '0;
                    rd_resp_q <= 2'b00;
                    r_state_q <= rd_reject_d ? R_REJ : R_ADDR;
                end
                R_ADDR: if (m_axi_arready) r_state_q <= R_DATA;
                R_DATA: if (r_hs) begin
                    r_cnt_q <= r_cnt_q + 8'd1;
                    if (m_axi_rlast) begin
                        // early or late RLAST means the slave broke the burst length
                        rd_resp_q <= (r_cnt_q != r_len_q) ? 2'b10 : rresp_max_d;
                        rd_done_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        rd_resp_q <= rresp_max_d;
                    end
                end
                R_REJ: begin
                    rd_resp_q <= 2'b10;
                    rd_done_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule
